regfile_wb_ctrl: RTL
====================

# regfile_wb_ctrl

Write-back controller and load scoreboard for the Beta register file. It arbitrates two write-back sources, the single-cycle ALU path and the variable-latency load-return path, onto the register file's single write port. It also tracks destination registers of in-flight loads so decode can stall on RAW hazards. It sits between the execute/memory stages and `regfile`, and drives `RegWrite`, `RegDst`, `rc` and `wdata`.

## Interface
- No parameters; 32 registers × 32 bits fixed, register 0 hardwired to zero.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `alu_valid` in 1: ALU result ready to write back.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `alu_ready` out 1: ALU write-back accepted this cycle.
- `ld_issue` in 1: load issuing this cycle; marks `ld_issue_rd` busy.
- `ld_issue_rd` in 5: destination of the issuing load.
- `ld_issue_ready` out 1: issue accepted, i.e. `!busy[ld_issue_rd]`.
- `ld_valid` in 1: load data returning.
- `ld_rd` in 5: returning load destination.
- `ld_data` in 32: returning load data.
- `ld_ready` out 1: load return accepted this cycle.
- `qa`, `qb` in 5: decode source-register queries.
- `hz_a`, `hz_b` out 1: `qa` / `qb` busy (always 0 for register 0).
- `busy` out 32: scoreboard vector; bit 0 always 0.
- `RegWrite` out 1: regfile write enable (registered).
- `RegDst` out 1: constant 0, so the regfile writes `rc`.
- `rc` out 5: regfile write address (registered).
- `wdata` out 32: regfile write data (registered).

## Operation
**Scoreboard**
- A handshake is `ld_issue && ld_issue_ready`. It sets `busy[ld_issue_rd]` at the clock edge, except for register 0, where no bit is set.
- Issuing a load to an already-busy register is refused via `ld_issue_ready=0`, so at most one load is outstanding per register.
- A bit clears at the edge where the regfile write of the matching load occurs: output stage valid with source = load. The bit is therefore still 1 during the cycle `RegWrite` is high. No bypass is needed.
- Set and clear of the same register in one cycle cannot occur: the issue is refused because the bit is still set.

**Eligibility**
- ALU is eligible when `alu_valid && !busy[alu_rd]`. The busy check preserves write-after-write (WAW) order behind an older load.
- Load is eligible when `ld_valid`.

**Arbitration**
- Round-robin using a 1-bit `last` flag. On conflict, the source not equal to `last` wins; `last` updates to the winner on every grant.
- With a single eligible source, that source is granted.
- `alu_ready` / `ld_ready` are combinational: high only for the granted source. The write port never back-pressures, so at most one grant per cycle.

**Output stage**
- On a grant, the stage registers `RegWrite=1`, `rc`, `wdata` and the source tag.
- With no grant, `RegWrite=0` next cycle. `rc` and `wdata` hold.
- A grant to `rd=0` completes the handshake but registers `RegWrite=0`. A load to register 0 never set busy, so it clears nothing.

## Timing
- Grant at cycle N → `RegWrite`/`rc`/`wdata` valid in cycle N+1 → regfile updated at the end of N+1.
- For loads, the busy bit clears at the end of N+1, so `hz` is 0 from N+2.
- `hz_*`, `ld_issue_ready`, `alu_ready` and `ld_ready` depend combinationally on the current `busy` and request inputs.
- Sustained throughput: one write per cycle.
- Reset values: `busy=0`, `RegWrite=0`, `RegDst=0`, `rc=0`, `wdata=0`, `last=ALU`, so the load wins the first conflict.
- Reset mid-operation: all busy bits and any registered write are discarded. Load returns arriving after reset are accepted and written normally.

## Test plan
- **Reset:** after `reset`, `busy=0`, `RegWrite=0`, `rc=0`, `wdata=0`, `RegDst=0`.
- **ALU write:** `alu_valid`, rd=5, data=0x1234 at cycle N → `alu_ready=1` at N; `RegWrite=1`, `rc=5`, `wdata=0x1234` at N+1; `RegWrite=0` at N+2.
- **Load scoreboard:** issue rd=7; check `busy[7]=1` and `hz_a=1` for `qa=7`. Re-issue rd=7 → `ld_issue_ready=0`. Return rd=7, data=0xCAFE → write at the next cycle; `hz_a=0` two cycles after the return handshake.
- **WAW stall:** rd=9 busy, `alu_valid` with rd=9 → `alu_ready=0` until the load to 9 has written, then ALU granted. Final content of r9 is the ALU data.
- **Round-robin:** ALU and load both valid every cycle for 4 cycles on non-busy regs → grants L, A, L, A; `RegWrite` high 4 consecutive cycles.
- **Register 0:** issue to r0 → `busy` stays 0. ALU to rd=0 → `alu_ready=1`, `RegWrite=0` next cycle. Reset asserted mid-stream while `busy[3]=1` → `busy=0` next cycle.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
// Write-back arbiter (ALU vs. load return) onto the single regfile write port,
// plus a per-register scoreboard of in-flight loads for decode hazard checks.
module regfile_wb_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  output logic        ld_issue_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic [4:0]  qa,
  input  logic [4:0]  qb,
  output logic        hz_a,
  output logic        hz_b,
  output logic [31:0] busy,
  output logic        RegWrite,
  output logic        RegDst,
  output logic [4:0]  rc,
  output logic [31:0] wdata
);

  typedef enum logic {SrcAlu = 1'b0, SrcLd = 1'b1} src_e;

  src_e        last_q, src_q;
  logic [31:0] busy_q, busy_d;
  logic        regwrite_q;
  logic [4:0]  rc_q;
  logic [31:0] wdata_q;
  logic        alu_elig, grant_alu, grant_ld;

  assign alu_elig       = alu_valid && !busy_q[alu_rd];
  // On conflict the source that did not win last time takes the port.
  assign grant_alu      = alu_elig && (!ld_valid || (last_q == SrcLd));
  assign grant_ld       = ld_valid && (!alu_elig || (last_q == SrcAlu));
  assign alu_ready      = grant_alu;
  assign ld_ready       = grant_ld;
  assign ld_issue_ready = !busy_q[ld_issue_rd];
  assign hz_a           = busy_q[qa];
  assign hz_b           = busy_q[qb];
  assign busy           = busy_q;
  assign RegWrite       = regwrite_q;
  assign RegDst         = 1'b0;
  assign rc             = rc_q;
  assign wdata          = wdata_q;

  always_comb begin
    busy_d = busy_q;
    // Bit stays set through the RegWrite cycle and drops at its closing edge.
    if (regwrite_q && (src_q == SrcLd)) busy_d[rc_q] = 1'b0;
    if (ld_issue && ld_issue_ready && (ld_issue_rd != 5'd0)) busy_d[ld_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q     <= '0;
      regwrite_q <= 1'b0;
      rc_q       <= '0;
      wdata_q    <= '0;
      last_q     <= SrcAlu;
      src_q      <= SrcAlu;
    end else begin
      busy_q     <= busy_d;
      regwrite_q <= 1'b0;
      if (grant_alu) begin
        regwrite_q <= (alu_rd != 5'd0);
        rc_q       <= alu_rd;
        wdata_q    <= alu_data;
        src_q      <= SrcAlu;
        last_q     <= SrcAlu;
      end else if (grant_ld) begin
        regwrite_q <= (ld_rd != 5'd0);
        rc_q       <= ld_rd;
        wdata_q    <= ld_data;
        src_q      <= SrcLd;
        last_q     <= SrcLd;
      end
    end
  end

endmodule
